// File: rtl/svi_fanout_iso_if.sv
// SVI fanout bundle: source side, per-channel isolation requests and channel outputs.
// Drop-detect signals exist only when SVI_FANOUT_DROP_DETECT_EN is defined.
interface svi_fanout_iso_if #(
    parameter int unsigned W      = 2,
    parameter int unsigned NUM_CH = 2
);
    logic [W-1:0]          src_data;
    logic                  src_valid;
    logic [NUM_CH-1:0]     iso_req;
    logic [NUM_CH*W-1:0]   ch_data;
    logic [NUM_CH-1:0]     ch_valid;
    logic [NUM_CH-1:0]     iso_ack;
`ifdef SVI_FANOUT_DROP_DETECT_EN
    logic [NUM_CH-1:0]     dropped;
    logic [NUM_CH-1:0]     dropped_clr;
`endif

    modport master (
        output src_data,
        output src_valid,
        output iso_req,
`ifdef SVI_FANOUT_DROP_DETECT_EN
        output dropped_clr,
        input  dropped,
`endif
        input  ch_data,
        input  ch_valid,
        input  iso_ack
    );

    modport slave (
        input  src_data,
        input  src_valid,
        input  iso_req,
`ifdef SVI_FANOUT_DROP_DETECT_EN
        input  dropped_clr,
        output dropped,
`endif
        output ch_data,
        output ch_valid,
        output iso_ack
    );
endinterface

// File: rtl/svi_fanout_iso.sv
// Fans a registered SVI bundle out to NUM_CH switchable domains, each with its own isolation FSM.
// Optional sticky drop flags are built when SVI_FANOUT_DROP_DETECT_EN is defined.
module svi_fanout_iso #(
    parameter int unsigned W          = 2,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned SETTLE_CYC = 4,
    parameter logic [W-1:0] CLAMP_VAL = '0
) (
    input logic             ck,
    input logic             arst,
    svi_fanout_iso_if.slave bus
);

    localparam int unsigned CntW = (SETTLE_CYC <= 1) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [CntW-1:0] CntLast = (SETTLE_CYC == 0) ? '0 : CntW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        StActive   = 2'd0,
        StIsolated = 2'd1,
        StSettle   = 2'd2
    } state_e;

    logic [W-1:0] src_q;
    logic         src_vq;

    always_ff @(posedge ck) begin
        if (arst) begin
            src_q  <= '0;
            src_vq <= 1'b0;
        end else begin
            src_q  <= bus.src_data;
            src_vq <= bus.src_valid;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_e          state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic [W-1:0]    data_c;
        logic            valid_c;
        logic            ack_c;

        always_ff @(posedge ck) begin
            if (arst) begin
                state_q <= StIsolated;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                StActive: begin
                    if (bus.iso_req[i]) begin
                        state_d = StIsolated;
                    end
                end
                StIsolated: begin
                    if (!bus.iso_req[i]) begin
                        if (SETTLE_CYC == 0) begin
                            state_d = StActive;
                        end else begin
                            state_d = StSettle;
                            cnt_d   = '0;
                        end
                    end
                end
                StSettle: begin
                    if (bus.iso_req[i]) begin
                        state_d = StIsolated;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StActive;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIsolated;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs depend only on registered state and registered source data.
        always_comb begin
            data_c  = CLAMP_VAL;
            valid_c = 1'b0;
            ack_c   = 1'b0;
            unique case (state_q)
                StActive: begin
                    data_c  = src_q;
                    valid_c = src_vq;
                end
                StIsolated: ack_c = 1'b1;
                default: ;
            endcase
        end

        assign bus.ch_data[i*W +: W] = data_c;
        assign bus.ch_valid[i]       = valid_c;
        assign bus.iso_ack[i]        = ack_c;

`ifdef SVI_FANOUT_DROP_DETECT_EN
        logic dropped_q;

        // Set wins over a simultaneous clear.
        always_ff @(posedge ck) begin
            if (arst) begin
                dropped_q <= 1'b0;
            end else if (src_vq && (state_q != StActive)) begin
                dropped_q <= 1'b1;
            end else if (bus.dropped_clr[i]) begin
                dropped_q <= 1'b0;
            end
        end

        assign bus.dropped[i] = dropped_q;
`endif
    end

endmodule
